// File: rtl/uart_arb_pkg.sv
// Shared types and default constants for the UART TX arbiter.
package uart_arb_pkg;

   localparam int DEF_N_REQ     = 4;
   localparam int DEF_DATA_BITS = 8;
   localparam int DEF_TIMEOUT   = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request bit at or after the pointer, wrapping.
module rr_picker
   import uart_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] pointer,
   output logic [IDX_W-1:0] index,
   output logic             valid
);

   // Scan farthest to nearest so the nearest set bit at or after the pointer wins.
   always_comb begin
      index = '0;
      valid = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[(int'(pointer) + k) % N_REQ]) begin
            index = IDX_W'((int'(pointer) + k) % N_REQ);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Burst-locking round-robin arbiter sharing one UART TX FIFO among requesters.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ     = DEF_N_REQ,
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*DATA_BITS-1:0] req_data,
   input  logic [N_REQ-1:0]           req_last,
   output logic [N_REQ-1:0]           ack,
   output logic [N_REQ-1:0]           grant,
   input  logic                       tx_full,
   output logic                       wr_uart,
   output logic [DATA_BITS-1:0]       wr_data,
   output logic                       busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

   arb_state_t       state, state_nxt;
   logic [IDX_W-1:0] owner, owner_nxt;
   logic [IDX_W-1:0] pointer, pointer_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_valid;
   logic                 owner_req;
   logic                 owner_last;
   logic [DATA_BITS-1:0] owner_data;
   logic [IDX_W-1:0]     after_owner;

   rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req     (req),
      .pointer (pointer),
      .index   (pick_idx),
      .valid   (pick_valid)
   );

   assign owner_req   = req[owner];
   assign owner_last  = req_last[owner];
   assign owner_data  = req_data[int'(owner)*DATA_BITS +: DATA_BITS];
   assign after_owner = (owner == IDX_LAST) ? '0 : owner + 1'b1;

   // State, owner, round-robin pointer and stall counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         owner   <= '0;
         pointer <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         owner   <= owner_nxt;
         pointer <= pointer_nxt;
         cnt     <= cnt_nxt;
      end
   end

   // Grant selection, beat forwarding, burst end and stall-timeout release.
   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      pointer_nxt = pointer;
      cnt_nxt     = cnt;
      grant       = '0;
      ack         = '0;
      wr_uart     = 1'b0;
      wr_data     = '0;
      busy        = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               owner_nxt = pick_idx;
               cnt_nxt   = '0;
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            grant[owner] = 1'b1;
            busy         = 1'b1;
            if (!tx_full) begin
               if (owner_req) begin
                  wr_uart    = 1'b1;
                  wr_data    = owner_data;
                  ack[owner] = 1'b1;
                  cnt_nxt    = '0;
                  if (owner_last) begin
                     state_nxt   = IDLE;
                     pointer_nxt = after_owner;
                  end
               end else if (cnt >= CNT_LAST) begin
                  state_nxt   = IDLE;
                  pointer_nxt = after_owner;
                  cnt_nxt     = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic
// compared every cycle against a queue-free behavioural model of the arbitration rules.
module tb_uart_tx_arbiter;

   localparam int N_REQ     = 4;
   localparam int DATA_BITS = 8;
   localparam int TIMEOUT   = 16;

   logic                       clk = 1'b0;
   logic                       reset;
   logic [N_REQ-1:0]           req;
   logic [N_REQ*DATA_BITS-1:0] req_data;
   logic [N_REQ-1:0]           req_last;
   logic [N_REQ-1:0]           ack;
   logic [N_REQ-1:0]           grant;
   logic                       tx_full;
   logic                       wr_uart;
   logic [DATA_BITS-1:0]       wr_data;
   logic                       busy;

   int n_checks = 0;
   int n_fails  = 0;

   // Behavioural model: current owner (-1 when nobody holds the bus), next
   // requester to favour, and how many consecutive non-full cycles the owner
   // has left its request low.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_stall = 0;
   logic [N_REQ-1:0] exp_ack = '0;

   uart_tx_arbiter #(
      .N_REQ     (N_REQ),
      .DATA_BITS (DATA_BITS),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_data (req_data),
      .req_last (req_last),
      .ack      (ack),
      .grant    (grant),
      .tx_full  (tx_full),
      .wr_uart  (wr_uart),
      .wr_data  (wr_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] l,
                                input logic f, input logic [N_REQ*DATA_BITS-1:0] d);
      @(posedge clk);
      #1;
      req      = r;
      req_last = l;
      tx_full  = f;
      req_data = d;
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      reset    = 1'b1;
      req      = '0;
      req_last = '0;
      tx_full  = 1'b0;
      req_data = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Per-cycle reference: derive the required outputs from the model, compare, then advance the model.
   always @(negedge clk) begin
      logic [N_REQ-1:0]     e_grant;
      logic [N_REQ-1:0]     e_ack;
      logic                 e_wr;
      logic                 e_busy;
      logic [DATA_BITS-1:0] e_data;
      int                   pick;
      e_grant = '0;
      e_ack   = '0;
      e_wr    = 1'b0;
      e_busy  = 1'b0;
      e_data  = '0;
      pick    = -1;
      if (reset) begin
         m_owner = -1;
         m_ptr   = 0;
         m_stall = 0;
      end else if (m_owner < 0) begin
         for (int k = N_REQ - 1; k >= 0; k--)
            if (req[(m_ptr + k) % N_REQ]) pick = (m_ptr + k) % N_REQ;
         if (pick >= 0) begin
            m_owner = pick;
            m_stall = 0;
         end
      end else begin
         e_grant[m_owner] = 1'b1;
         e_busy           = 1'b1;
         if (!tx_full && req[m_owner]) begin
            e_wr           = 1'b1;
            e_data         = req_data[m_owner*DATA_BITS +: DATA_BITS];
            e_ack[m_owner] = 1'b1;
            m_stall        = 0;
            if (req_last[m_owner]) begin
               m_ptr   = (m_owner + 1) % N_REQ;
               m_owner = -1;
            end
         end else if (!tx_full) begin
            m_stall++;
            if (m_stall == TIMEOUT) begin
               m_ptr   = (m_owner + 1) % N_REQ;
               m_owner = -1;
               m_stall = 0;
            end
         end
      end
      checkOutput("model_grant", 32'(grant), 32'(e_grant));
      checkOutput("model_ack", 32'(ack), 32'(e_ack));
      checkOutput("model_wr_uart", 32'(wr_uart), 32'(e_wr));
      checkOutput("model_wr_data", 32'(wr_data), 32'(e_data));
      checkOutput("model_busy", 32'(busy), 32'(e_busy));
      exp_ack = e_ack;
   end

   int                   remaining [N_REQ];
   int                   pause     [N_REQ];
   logic [DATA_BITS-1:0] cur       [N_REQ];
   logic [N_REQ-1:0]           r_next;
   logic [N_REQ-1:0]           l_next;
   logic [N_REQ*DATA_BITS-1:0] d_next;
   int grant_order [10] = '{0, 1, 0, 2, 0, 4, 0, 8, 0, 1};

   initial begin
      reset    = 1'b1;
      req      = '0;
      req_last = '0;
      tx_full  = 1'b0;
      req_data = '0;

      // Single 3-beat burst from requester 2, then pointer lands on 3.
      doReset();
      @(negedge clk);
      checkOutput("reset_grant", 32'(grant), 32'h0);
      applyStimulus(4'b0100, 4'b0000, 1'b0, 32'h0041_0000);
      @(negedge clk);
      checkOutput("burst_idle_wr", 32'(wr_uart), 32'h0);
      applyStimulus(4'b0100, 4'b0000, 1'b0, 32'h0041_0000);
      @(negedge clk);
      checkOutput("burst_beat1_data", 32'(wr_data), 32'h41);
      checkOutput("burst_beat1_ack", 32'(ack), 32'h4);
      applyStimulus(4'b0100, 4'b0000, 1'b0, 32'h0042_0000);
      @(negedge clk);
      checkOutput("burst_beat2_data", 32'(wr_data), 32'h42);
      applyStimulus(4'b0100, 4'b0100, 1'b0, 32'h0043_0000);
      @(negedge clk);
      checkOutput("burst_beat3_data", 32'(wr_data), 32'h43);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("burst_end_busy", 32'(busy), 32'h0);
      applyStimulus(4'b1111, 4'b1111, 1'b0, 32'h4433_2211);
      @(negedge clk);
      checkOutput("ptr_idle_grant", 32'(grant), 32'h0);
      applyStimulus(4'b1111, 4'b1111, 1'b0, 32'h4433_2211);
      @(negedge clk);
      checkOutput("ptr_grant3", 32'(grant), 32'h8);
      checkOutput("ptr_grant3_data", 32'(wr_data), 32'h44);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);

      // Contention from reset: 0,1,2,3,0 with an idle cycle between grants.
      doReset();
      for (int c = 0; c < 10; c++) begin
         applyStimulus(4'b1111, 4'b1111, 1'b0, 32'h4433_2211);
         @(negedge clk);
         checkOutput($sformatf("rr_grant_c%0d", c), 32'(grant), 32'(grant_order[c]));
      end
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);

      // Backpressure mid-burst: grant held, no writes, no timeout.
      doReset();
      applyStimulus(4'b0010, 4'b0000, 1'b0, 32'h0000_5500);
      applyStimulus(4'b0010, 4'b0000, 1'b0, 32'h0000_5500);
      @(negedge clk);
      checkOutput("bp_beat1_data", 32'(wr_data), 32'h55);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'b0010, 4'b0010, 1'b1, 32'h0000_6600);
         @(negedge clk);
         checkOutput("bp_full_wr", 32'(wr_uart), 32'h0);
         checkOutput("bp_full_grant", 32'(grant), 32'h2);
      end
      applyStimulus(4'b0010, 4'b0010, 1'b0, 32'h0000_6600);
      @(negedge clk);
      checkOutput("bp_beat2_wr", 32'(wr_uart), 32'h1);
      checkOutput("bp_beat2_data", 32'(wr_data), 32'h66);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);

      // Timeout: requester 0 stalls, requester 3 waiting.
      doReset();
      applyStimulus(4'b0001, 4'b0000, 1'b0, 32'h0000_0011);
      applyStimulus(4'b0001, 4'b0000, 1'b0, 32'h0000_0011);
      @(negedge clk);
      checkOutput("to_beat_data", 32'(wr_data), 32'h11);
      for (int c = 0; c < TIMEOUT; c++) begin
         applyStimulus(4'b1000, 4'b1000, 1'b0, 32'h3300_0000);
         @(negedge clk);
         checkOutput("to_hold_grant", 32'(grant), 32'h1);
      end
      applyStimulus(4'b1000, 4'b1000, 1'b0, 32'h3300_0000);
      @(negedge clk);
      checkOutput("to_release_grant", 32'(grant), 32'h0);
      applyStimulus(4'b1000, 4'b1000, 1'b0, 32'h3300_0000);
      @(negedge clk);
      checkOutput("to_new_grant", 32'(grant), 32'h8);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);

      // Reset in the middle of a burst from requester 2.
      doReset();
      applyStimulus(4'b0100, 4'b0000, 1'b0, 32'h00A0_0000);
      applyStimulus(4'b0100, 4'b0000, 1'b0, 32'h00A0_0000);
      @(negedge clk);
      checkOutput("rst_beat1_data", 32'(wr_data), 32'hA0);
      applyStimulus(4'b0100, 4'b0000, 1'b0, 32'h00A1_0000);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid_grant", 32'(grant), 32'h0);
      checkOutput("rst_mid_wr", 32'(wr_uart), 32'h0);
      checkOutput("rst_mid_data", 32'(wr_data), 32'h0);
      applyStimulus(4'b0110, 4'b0110, 1'b0, 32'h00BB_CC00);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_after_idle", 32'(grant), 32'h0);
      applyStimulus(4'b0110, 4'b0110, 1'b0, 32'h00BB_CC00);
      @(negedge clk);
      checkOutput("rst_after_grant", 32'(grant), 32'h2);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);

      // Isolation: requester 3 churns data while requester 0 owns the bus.
      doReset();
      applyStimulus(4'b1001, 4'b0000, 1'b0, 32'h7700_005A);
      for (int b = 0; b < 4; b++) begin
         d_next = '0;
         d_next[31:24] = 8'($urandom);
         d_next[7:0]   = 8'(8'h5A + b);
         applyStimulus(4'b1001, (b == 3) ? 4'b0001 : 4'b0000, 1'b0, d_next);
         @(negedge clk);
         checkOutput("iso_ack3", 32'(ack[3]), 32'h0);
         checkOutput("iso_wr_data", 32'(wr_data), 32'(8'h5A + b));
      end
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);

      // Random traffic: bursts of 1-4 beats, random backpressure, occasional long pauses.
      doReset();
      for (int i = 0; i < N_REQ; i++) begin
         remaining[i] = 0;
         pause[i]     = 0;
         cur[i]       = '0;
      end
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         #1;
         for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && exp_ack[i]) begin
               remaining[i]--;
               cur[i] = 8'($urandom);
               if (remaining[i] > 0 && $urandom_range(0, 39) == 0)
                  pause[i] = TIMEOUT + 4;
               else if (remaining[i] > 0 && $urandom_range(0, 7) == 0)
                  pause[i] = int'($urandom_range(1, 3));
            end else if (!req[i]) begin
               if (pause[i] > 0)
                  pause[i]--;
               else if (remaining[i] == 0 && $urandom_range(0, 3) == 0) begin
                  remaining[i] = int'($urandom_range(1, 4));
                  cur[i]       = 8'($urandom);
               end
            end
            r_next[i] = (remaining[i] > 0) && (pause[i] == 0);
            l_next[i] = (remaining[i] == 1);
            d_next[i*DATA_BITS +: DATA_BITS] = cur[i];
         end
         applyStimulus(r_next, l_next, ($urandom_range(0, 3) == 0), d_next);
      end
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
